// File: rtl/rgb2gray_stream.sv
// rgb2gray_stream: two-stage RGB888 -> 8-bit luma stream with frame tags.
// Luma = (77R + 150G + 29B + K) >> 8, carried through a valid/ready pipeline
// that stalls as a whole when the downstream stage is not accepting.
// Optional macro RGB2GRAY_ROUND_EN: K = 128 (round-half-up); undefined: K = 0.
module rgb2gray_stream #(
    parameter int IMG_W = 48,
    parameter int IMG_H = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pix_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  gray_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

`ifdef RGB2GRAY_ROUND_EN
    localparam logic [16:0] ROUND_K = 17'd128;
`else
    localparam logic [16:0] ROUND_K = 17'd0;
`endif

    logic          en;
    logic          in_fire;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          tag_sof;
    logic          tag_eol;
    logic          tag_eof;

    logic [15:0]   s1_pr;
    logic [15:0]   s1_pg;
    logic [15:0]   s1_pb;
    logic          s1_valid;
    logic          s1_sof;
    logic          s1_eol;
    logic          s1_eof;

    logic [16:0]   sum;

    logic [7:0]    s2_gray;
    logic          s2_valid;
    logic          s2_sof;
    logic          s2_eol;
    logic          s2_eof;

    // The whole pipeline moves together: it advances whenever the output
    // slot is empty or being drained this cycle.
    assign en       = out_ready || !s2_valid;
    assign in_ready = en;
    assign in_fire  = in_valid && en;

    // Position tags are taken from the counters at the moment of acceptance.
    assign tag_sof = (col == '0) && (row == '0);
    assign tag_eol = (col == COL_LAST);
    assign tag_eof = (col == COL_LAST) && (row == ROW_LAST);

    // Track the raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_fire) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Stage 1: weighted channel products plus valid and tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_pr    <= '0;
            s1_pg    <= '0;
            s1_pb    <= '0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else if (en) begin
            s1_pr    <= 16'(pix_in[23:16]) * 16'd77;
            s1_pg    <= 16'(pix_in[15:8]) * 16'd150;
            s1_pb    <= 16'(pix_in[7:0]) * 16'd29;
            s1_valid <= in_valid;
            s1_sof   <= tag_sof;
            s1_eol   <= tag_eol;
            s1_eof   <= tag_eof;
        end
    end

    // The weights add to 256, so the 17-bit sum plus rounding never
    // reaches 2^16 and the shifted result always fits 8 bits.
    assign sum = 17'(s1_pr) + 17'(s1_pg) + 17'(s1_pb) + ROUND_K;

    // Stage 2: summed and scaled luma plus valid and tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_gray  <= '0;
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
        end else if (en) begin
            s2_gray  <= 8'(sum >> 8);
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_eof   <= s1_eof;
        end
    end

    assign gray_out  = s2_gray;
    assign out_valid = s2_valid;
    assign out_sof   = s2_sof && s2_valid;
    assign out_eol   = s2_eol && s2_valid;
    assign out_eof   = s2_eof && s2_valid;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb_rgb2gray_stream: scoreboard bench for rgb2gray_stream on a 4x2 frame.
// Accepted pixels push their expected luma and tags; an output monitor
// compares every presented output against the head of the queue.
module tb_rgb2gray_stream;

    localparam int W = 4;
    localparam int H = 2;

`ifdef RGB2GRAY_ROUND_EN
    localparam int K = 128;
    localparam logic [7:0] EXP_020000 = 8'h01;
`else
    localparam int K = 0;
    localparam logic [7:0] EXP_020000 = 8'h00;
`endif

    logic        clk;
    logic        rst;
    logic [23:0] pix_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  gray_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eol;
    logic        out_eof;

    typedef struct {
        logic [7:0] g;
        logic       sof;
        logic       eol;
        logic       eof;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] dq[$];
    exp_t       it;
    exp_t       e;
    int         pos = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         lat_check = 0;

    rgb2gray_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_out  (gray_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc++;

    // Reference luma: weighted average of the channels with scale 256.
    function automatic logic [7:0] refLuma(input logic [23:0] p);
        int r;
        int g;
        int b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 8'((77 * r + 150 * g + 29 * b + K) / 256);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input side of the scoreboard: every accepted pixel gets an expected entry.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            dq.delete();
            pos = 0;
        end else if (in_valid && in_ready) begin
            it.g   = (dq.size() > 0) ? dq.pop_front() : refLuma(pix_in);
            it.sof = (pos == 0);
            it.eol = ((pos % W) == W - 1);
            it.eof = (pos == W * H - 1);
            it.cyc = cyc;
            sb.push_back(it);
            pos = (pos + 1) % (W * H);
        end
    end

    // Output side: compare presented outputs (stalled ones too), pop on transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    checkOutput("gray", 32'(gray_out), 32'(e.g));
                    checkOutput("tags_sof_eol_eof", 32'({out_sof, out_eol, out_eof}),
                                32'({e.sof, e.eol, e.eof}));
                    if (out_ready) begin
                        if (lat_check)
                            checkOutput("latency", 32'(cyc - e.cyc), 32'd2);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                checkOutput("idle_tags", 32'({out_sof, out_eol, out_eof}), 32'd0);
            end
        end
    end

    // Drive one pixel for one cycle; called just after a rising edge.
    task automatic applyStimulus(input logic [23:0] p, input logic rdy);
        pix_in    = p;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [23:0] dpix [5];
        logic [7:0]  dexp [5];
        bit          acc;
        int          n;

        rst       = 1'b1;
        pix_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_gray", 32'(gray_out), 32'd0);
        checkOutput("reset_tags", 32'({out_sof, out_eol, out_eof}), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed luma values with known constant results and latency 2.
        dpix = '{24'hFFFFFF, 24'h000000, 24'h808080, 24'h010000, 24'h020000};
        dexp = '{8'hFF, 8'h00, 8'h80, 8'h00, EXP_020000};
        lat_check = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dq.push_back(dexp[i]);
            applyStimulus(dpix[i], 1'b1);
        end
        waitDrain(20);
        lat_check = 1'b0;

        // Continuous two-frame stream for tag placement.
        doReset();
        for (int i = 0; i < 2 * W * H; i++)
            applyStimulus(24'($urandom), 1'b1);
        waitDrain(20);

        // Random in_valid / out_ready over several frames.
        doReset();
        n   = 0;
        acc = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && n < 6 * W * H; c++) begin
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                pix_in   = 24'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) n++;
            @(posedge clk);
            #1;
        end
        checkOutput("random_accepted", 32'(n), 32'(6 * W * H));
        waitDrain(40);

        // Reset mid-line after 5 pixels; next pixel must restart the frame.
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(24'($urandom), 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(24'($urandom), 1'b1);
        waitDrain(20);

        // Fill both stages with out_ready low, then release.
        doReset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pix_in    = 24'h3366CC;
        @(posedge clk);
        #1;
        pix_in = 24'hC0FFEE;
        @(posedge clk);
        #1;
        pix_in = 24'h123456;
        #1;
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        waitDrain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
